buf_loader: RTL and testbench

Host-side loader that fills the command buffer of the buffer executor and kicks it off. Accepts a framed byte stream (from the UART/SPI host link), assembles 40-bit command words, and drives the executor's buffer write port and start/abort controls. Sits between the host byte interface and the executor's ext_buffer_* / start / start_addr / abort inputs.

---
 rtl/buf_loader_if.sv | 31 +++
 rtl/buf_loader.sv | 174 +++++++++++++++++
 tb/tb_buf_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/buf_loader_if.sv
// Host byte stream, buffer write port and executor controls of buf_loader.
// master = host/executor side, slave = the loader itself.
`timescale 1ns/1ps
interface buf_loader_if;
  // Byte handshake: a byte moves on a rising clk edge where in_valid && in_ready;
  // the host holds in_data/in_valid stable until then, in_ready never depends on in_valid.
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] buf_addr;
  logic [39:0] buf_data;
  logic        buf_wr;
  logic        start;
  logic [15:0] start_addr;
  logic        abort;
  logic        frame_done;
  logic [7:0]  frame_err;
  logic [2:0]  fsm_state;

  modport master (
    output in_data, in_valid,
    input  in_ready, buf_addr, buf_data, buf_wr, start, start_addr, abort,
           frame_done, frame_err, fsm_state
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, buf_addr, buf_data, buf_wr, start, start_addr, abort,
           frame_done, frame_err, fsm_state
  );
endinterface

// File: rtl/buf_loader.sv
// Framed byte-stream loader for the executor command buffer (write/start/abort).
// Optional trailing checksum byte: define BUF_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module buf_loader #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_W      = 17
) (
  input logic        clk,
  input logic        rst,
  buf_loader_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA, S_CSUM, S_ISSUE
  } state_t;

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_S = 8'h53;
  localparam logic [7:0] OP_A = 8'h41;

  // S_TAIL is where a frame goes once its last field byte has arrived.
`ifdef BUF_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_ISSUE;
`endif
  localparam logic TAIL_READY = (S_TAIL != S_ISSUE);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [7:0]           opcode;
  logic [15:0]          addr;
  logic [15:0]          cnt;
  logic [2:0]           byte_idx;
  logic [31:0]          word_sh;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 accept;
  logic                 in_frame;
  logic                 timeout;
  logic                 sum_ok;

  assign accept        = bus.in_valid && bus.in_ready;
  assign in_frame      = (state != S_IDLE) && (state != S_ISSUE);
  assign timeout       = in_frame && !accept && (tmo_cnt == TMO_LAST);
  assign bus.fsm_state = state;

`ifdef BUF_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // The opcode restarts the sum, so a dropped frame leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst)
      csum <= '0;
    else if (accept)
      csum <= (state == S_IDLE) ? bus.in_data : csum + bus.in_data;
  end

  assign sum_ok = (csum == 8'h00);
`else
  assign sum_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      opcode         <= '0;
      addr           <= '0;
      cnt            <= '0;
      byte_idx       <= '0;
      word_sh        <= '0;
      tmo_cnt        <= '0;
      bus.in_ready   <= 1'b0;
      bus.buf_addr   <= '0;
      bus.buf_data   <= '0;
      bus.buf_wr     <= 1'b0;
      bus.start      <= 1'b0;
      bus.start_addr <= '0;
      bus.abort      <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= '0;
    end else begin
      bus.in_ready   <= 1'b1;
      bus.buf_wr     <= 1'b0;
      bus.start      <= 1'b0;
      bus.abort      <= 1'b0;
      bus.frame_done <= 1'b0;
      tmo_cnt        <= (in_frame && !accept) ? tmo_cnt + 1'b1 : '0;

      case (state)
        S_IDLE: if (accept) begin
          opcode <= bus.in_data;
          if (bus.in_data == OP_W || bus.in_data == OP_S || bus.in_data == OP_A) begin
            state <= S_ADDR_H;
          end else begin
            bus.frame_err  <= 8'h01;
            bus.frame_done <= 1'b1;
          end
        end
        S_ADDR_H: if (accept) begin
          addr[15:8] <= bus.in_data;
          state      <= S_ADDR_L;
        end
        S_ADDR_L: if (accept) begin
          addr[7:0] <= bus.in_data;
          if (opcode == OP_W) begin
            state <= S_CNT_H;
          end else begin
            state        <= S_TAIL;
            bus.in_ready <= TAIL_READY;
          end
        end
        S_CNT_H: if (accept) begin
          cnt[15:8] <= bus.in_data;
          state     <= S_CNT_L;
        end
        S_CNT_L: if (accept) begin
          cnt[7:0] <= bus.in_data;
          byte_idx <= '0;
          if ({cnt[15:8], bus.in_data} == 16'd0) begin
            state        <= S_TAIL;
            bus.in_ready <= TAIL_READY;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (accept) begin
          if (byte_idx == 3'd4) begin
            bus.buf_data <= {word_sh, bus.in_data};
            bus.buf_addr <= addr;
            bus.buf_wr   <= 1'b1;
            addr         <= addr + 16'd1;
            cnt          <= cnt - 16'd1;
            byte_idx     <= '0;
            if (cnt == 16'd1) begin
              state        <= S_TAIL;
              bus.in_ready <= TAIL_READY;
            end
          end else begin
            word_sh  <= {word_sh[23:0], bus.in_data};
            byte_idx <= byte_idx + 3'd1;
          end
        end
`ifdef BUF_LOADER_CHECKSUM_EN
        S_CSUM: if (accept) begin
          state        <= S_ISSUE;
          bus.in_ready <= 1'b0;
        end
`endif
        S_ISSUE: begin
          state          <= S_IDLE;
          bus.frame_done <= 1'b1;
          if (sum_ok) begin
            bus.frame_err <= 8'h00;
            if (opcode == OP_S) begin
              bus.start      <= 1'b1;
              bus.start_addr <= addr;
            end
            if (opcode == OP_A)
              bus.abort <= 1'b1;
          end else begin
            bus.frame_err <= 8'h02;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Only reachable with no byte accepted this cycle, so it never races a transition.
      if (timeout) begin
        state          <= S_IDLE;
        bus.frame_err  <= 8'h03;
        bus.frame_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_buf_loader.sv
// Randomized self-checking bench for buf_loader against a frame-level reference model.
`timescale 1ns/1ps
module tb_buf_loader;
  localparam int TMO = 40;
`ifdef BUF_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_S = 8'h53;
  localparam logic [7:0] OP_A = 8'h41;

  logic clk = 1'b0;
  logic rst = 1'b1;
  buf_loader_if bus();

  buf_loader #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_W(17)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [55:0] exp_wr_q[$];
  logic [15:0] exp_start_q[$];
  logic [7:0]  exp_done_q[$];
  int          exp_aborts = 0;
  logic [39:0] wq[$];
  int          max_gap = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.buf_wr === 1'b1) begin
      check("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
      if (exp_wr_q.size() != 0) begin
        logic [55:0] e;
        e = exp_wr_q.pop_front();
        check("wr_addr", 64'(bus.buf_addr), 64'(e[55:40]));
        check("wr_data", 64'(bus.buf_data), 64'(e[39:0]));
      end
    end
    if (bus.start === 1'b1) begin
      check("start_expected", 64'(exp_start_q.size() != 0), 64'd1);
      if (exp_start_q.size() != 0)
        check("start_addr", 64'(bus.start_addr), 64'(exp_start_q.pop_front()));
    end
    if (bus.abort === 1'b1) begin
      check("abort_expected", 64'(exp_aborts > 0), 64'd1);
      if (exp_aborts > 0) exp_aborts--;
    end
    if (bus.frame_done === 1'b1) begin
      check("done_expected", 64'(exp_done_q.size() != 0), 64'd1);
      if (exp_done_q.size() != 0)
        check("frame_err", 64'(bus.frame_err), 64'(exp_done_q.pop_front()));
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_wait", 64'(guard), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Builds a frame from op/addr/wq, records what the loader must do, then sends it.
  task automatic send_frame(input logic [7:0] op, input logic [15:0] addr,
                            input logic bad_sum, input int stall);
    logic [7:0]  fb[$];
    logic [7:0]  sum;
    logic [15:0] n;
    logic        ok;
    n = 16'(wq.size());
    fb.push_back(op);
    fb.push_back(addr[15:8]);
    fb.push_back(addr[7:0]);
    if (op == OP_W) begin
      fb.push_back(n[15:8]);
      fb.push_back(n[7:0]);
      foreach (wq[i])
        for (int k = 4; k >= 0; k--) fb.push_back(wq[i][k*8 +: 8]);
    end
    if (CSUM_EN) begin
      sum = 8'h00;
      foreach (fb[i]) sum = sum + fb[i];
      fb.push_back(8'(8'h00 - sum) + {7'd0, bad_sum});
    end
    ok = !(CSUM_EN && bad_sum);
    if (op == OP_W)
      foreach (wq[i]) exp_wr_q.push_back({16'(addr + 16'(i)), wq[i]});
    exp_done_q.push_back(ok ? 8'h00 : 8'h02);
    if (ok && op == OP_S) exp_start_q.push_back(addr);
    if (ok && op == OP_A) exp_aborts++;
    foreach (fb[i])
      send_byte(fb[i], (i == 2) ? stall : int'($urandom_range(0, max_gap)));
    wq.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] partial[8];
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_outputs", 64'({bus.buf_wr, bus.start, bus.abort, bus.frame_done}), 64'd0);
    check("rst_buf_addr", 64'(bus.buf_addr), 64'd0);
    check("rst_buf_data", 64'(bus.buf_data), 64'd0);
    check("rst_frame_err", 64'(bus.frame_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(bus.in_ready), 64'd1);

    // basic write block
    wq = '{40'h4112345678, 40'h8000000000};
    send_frame(OP_W, 16'h0010, 1'b0, 0);
    repeat (4) @(negedge clk);
    check("w_err_ok", 64'(bus.frame_err), 64'd0);

    // address wrap
    wq = '{40'h0102030405, 40'hA5A5A5A5A5};
    send_frame(OP_W, 16'hFFFF, 1'b0, 0);

    // start, good then corrupted checksum
    send_frame(OP_S, 16'h0010, 1'b0, 0);
    repeat (4) @(negedge clk);
    check("start_addr_hold", 64'(bus.start_addr), 64'h0010);
    send_frame(OP_S, 16'h0010, 1'b1, 0);
    repeat (4) @(negedge clk);
    check("csum_err", 64'(bus.frame_err), CSUM_EN ? 64'h02 : 64'h00);

    // unknown opcode then back-to-back abort frame
    exp_done_q.push_back(8'h01);
    send_byte(8'h99, 0);
    send_frame(OP_A, 16'h1234, 1'b0, 0);

    // long stall that stays under the timeout
    send_frame(OP_S, 16'h0BEE, 1'b0, TMO / 2);
    repeat (4) @(negedge clk);
    check("stall_no_tmo_err", 64'(bus.frame_err), 64'd0);

    // timeout inside a word: no write, error 3
    partial = '{8'h57, 8'h00, 8'h40, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
    exp_done_q.push_back(8'h03);
    foreach (partial[i]) send_byte(partial[i], 0);
    repeat (TMO + 5) @(negedge clk);
    check("tmo_err_hold", 64'(bus.frame_err), 64'h03);
    wq = '{40'hDEADBEEF01};
    send_frame(OP_W, 16'h0050, 1'b0, 0);

    // reset in the middle of a word
    partial = '{8'h57, 8'h00, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    foreach (partial[i]) send_byte(partial[i], 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("mid_rst_pulses", 64'({bus.buf_wr, bus.start, bus.abort, bus.frame_done}), 64'd0);
    check("mid_rst_start_addr", 64'(bus.start_addr), 64'd0);
    check("mid_rst_buf_addr", 64'(bus.buf_addr), 64'd0);
    check("mid_rst_frame_err", 64'(bus.frame_err), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wq = '{40'h123456789A};
    send_frame(OP_W, 16'h0030, 1'b0, 0);

    // randomized frames
    max_gap = 2;
    for (int f = 0; f < 40; f++) begin
      int          r;
      logic [15:0] a;
      logic [7:0]  b;
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFD + $urandom_range(0, 2))
                                      : 16'($urandom);
      if (r <= 4) begin
        int n;
        n = $urandom_range(0, 4);
        for (int w = 0; w < n; w++) wq.push_back({8'($urandom), 32'($urandom)});
        send_frame(OP_W, a, ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
      end else if (r <= 6) begin
        send_frame(OP_S, a, ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
      end else if (r <= 8) begin
        send_frame(OP_A, a, ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
      end else begin
        do b = 8'($urandom); while (b == OP_W || b == OP_S || b == OP_A);
        exp_done_q.push_back(8'h01);
        send_byte(b, $urandom_range(0, 2));
      end
    end

    repeat (10) @(negedge clk);
    check("wr_left", 64'(exp_wr_q.size()), 64'd0);
    check("start_left", 64'(exp_start_q.size()), 64'd0);
    check("abort_left", 64'(exp_aborts), 64'd0);
    check("done_left", 64'(exp_done_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
